rtc_alarm_top: RTL and testbench

RTC_ALARM_TOP -- requirements
Module: rtc_alarm_top

---
 rtl/rtc_alarm_top.sv | 192 +++++++++++++++++++
 tb/tb_rtc_alarm_top.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_alarm_top.sv
// Real-time clock with packed-BCD time of day, one alarm, and a Wishbone
// classic slave port. A prescaler turns clk_i into a once-per-second tick
// that advances SEC/MIN/HOUR in one edge. The alarm flag sets when a tick
// lands on the alarm time.
module rtc_alarm_top #(
    parameter int CLOCK_FREQ = 50000000,
    parameter int CNT_W      = 27
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    output logic        irq_o
);

    typedef enum logic [2:0] {
        REG_SEC      = 3'd0,
        REG_MIN      = 3'd1,
        REG_HOUR     = 3'd2,
        REG_ALM_SEC  = 3'd3,
        REG_ALM_MIN  = 3'd4,
        REG_ALM_HOUR = 3'd5,
        REG_CTRL     = 3'd6,
        REG_STATUS   = 3'd7
    } reg_addr_e;

    localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(CLOCK_FREQ - 1);

    // Next BCD value with carry. Invalid digits and values at or past the
    // limit both load 0x00 and carry, so a corrupt field recovers on one tick.
    function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        logic [8:0] r;
        if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v >= max_v)
            r = {1'b1, 8'h00};
        else if (v[3:0] == 4'd9)
            r = {1'b0, v[7:4] + 4'd1, 4'd0};
        else
            r = {1'b0, v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    reg_addr_e        reg_idx;
    logic             accept;
    logic             wr_en;
    logic             wr_time;
    logic             tick;
    logic             tick_apply;
    logic             alarm_hit;
    logic             alarm_clr;
    logic [CNT_W-1:0] presc;
    logic [7:0]       sec, min, hour;
    logic [7:0]       alm_sec, alm_min, alm_hour;
    logic             run, irq_en, alarm;
    logic [8:0]       sec_inc, min_inc, hour_inc;
    logic [7:0]       sec_nxt, min_nxt, hour_nxt;
    logic [7:0]       rd_data;
    logic [7:0]       rd_q;
    logic             unused_bits;

    assign reg_idx    = reg_addr_e'(adr_i[4:2]);
    assign accept     = cyc_i & stb_i & ~ack_o;
    assign wr_en      = accept & we_i & sel_i[0];
    assign wr_time    = wr_en & (reg_idx == REG_SEC || reg_idx == REG_MIN || reg_idx == REG_HOUR);
    assign tick       = run & (presc == PRESC_MAX);
    // A time write wins over a coincident tick: the written field is stored
    // and the other fields hold, so software sees exactly what it wrote.
    assign tick_apply = tick & ~wr_time;
    assign alarm_clr  = wr_en & (reg_idx == REG_STATUS) & dat_i[0];
    assign dat_o      = {24'd0, rd_q};
    assign unused_bits = ^{sel_i[3:1], adr_i[31:5], adr_i[1:0], dat_i[31:8]};

    // Full seconds->minutes->hours cascade and alarm compare for one tick.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        sec_inc   = bcd_inc(sec,  8'h59);
        min_inc   = bcd_inc(min,  8'h59);
        hour_inc  = bcd_inc(hour, 8'h23);
        sec_nxt   = sec_inc[7:0];
        min_nxt   = min;
        hour_nxt  = hour;
        if (sec_inc[8]) begin
            min_nxt = min_inc[7:0];
            if (min_inc[8])
                hour_nxt = hour_inc[7:0];
        end
        alarm_hit = tick_apply &&
                    ({hour_nxt, min_nxt, sec_nxt} == {alm_hour, alm_min, alm_sec});
    end

    // Read mux; reserved bits read as zero.
    always_comb begin
        rd_data = 8'h00;
        case (reg_idx)
            REG_SEC:      rd_data = sec;
            REG_MIN:      rd_data = min;
            REG_HOUR:     rd_data = hour;
            REG_ALM_SEC:  rd_data = alm_sec;
            REG_ALM_MIN:  rd_data = alm_min;
            REG_ALM_HOUR: rd_data = alm_hour;
            REG_CTRL:     rd_data = {6'd0, irq_en, run};
            REG_STATUS:   rd_data = {7'd0, alarm};
            default:      rd_data = 8'h00;
        endcase
    end

    // Bus handshake: one-cycle ack after each accepted request, read data captured at acceptance.
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_o <= 1'b0;
            rd_q  <= 8'h00;
        end else begin
            ack_o <= accept;
            if (accept)
                rd_q <= rd_data;
        end
    end

    // Prescaler: wraps at CLOCK_FREQ-1 while running, restarts on any time write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            presc <= '0;
        else if (wr_time)
            presc <= '0;
        else if (run)
            presc <= (presc == PRESC_MAX) ? '0 : presc + 1'b1;
    end

    // Time-of-day registers: bus write has priority, otherwise advance on tick.
    // NOTE: this small register file lives in flops, not RAM, so every entry has a defined reset value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sec  <= 8'h00;
            min  <= 8'h00;
            hour <= 8'h00;
        end else if (wr_time) begin
            case (reg_idx)
                REG_SEC:  sec  <= dat_i[7:0];
                REG_MIN:  min  <= dat_i[7:0];
                REG_HOUR: hour <= dat_i[7:0];
                default:  ;
            endcase
        end else if (tick_apply) begin
            sec  <= sec_nxt;
            min  <= min_nxt;
            hour <= hour_nxt;
        end
    end

    // Alarm time and control registers, written only from the bus.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alm_sec  <= 8'h00;
            alm_min  <= 8'h00;
            alm_hour <= 8'h00;
            run      <= 1'b1;
            irq_en   <= 1'b0;
        end else if (wr_en) begin
            case (reg_idx)
                REG_ALM_SEC:  alm_sec  <= dat_i[7:0];
                REG_ALM_MIN:  alm_min  <= dat_i[7:0];
                REG_ALM_HOUR: alm_hour <= dat_i[7:0];
                REG_CTRL: begin
                    run    <= dat_i[0];
                    irq_en <= dat_i[1];
                end
                default: ;
            endcase
        end
    end

    // Alarm flag (set beats write-1-to-clear) and registered interrupt level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alarm <= 1'b0;
            irq_o <= 1'b0;
        end else begin
            if (alarm_hit)
                alarm <= 1'b1;
            else if (alarm_clr)
                alarm <= 1'b0;
            irq_o <= alarm & irq_en;
        end
    end

endmodule

// File: tb/tb_rtc_alarm_top.sv
// Directed bench for rtc_alarm_top at CLOCK_FREQ=10: bus register map and
// reset values from a vector table, tick cascade from a second table, and
// hand-timed sequences for prescaler, alarm, write/tick collision and reset.
module tb_rtc_alarm_top;

    localparam int CLOCK_FREQ = 10;
    localparam int CNT_W      = 4;

    localparam logic [2:0] A_SEC = 3'd0, A_MIN = 3'd1, A_HOUR = 3'd2, A_ASEC = 3'd3,
                           A_AMIN = 3'd4, A_AHOUR = 3'd5, A_CTRL = 3'd6, A_STAT = 3'd7;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cyc_i = 1'b0;
    logic        stb_i = 1'b0;
    logic        we_i  = 1'b0;
    logic [3:0]  sel_i = 4'h0;
    logic [31:0] adr_i = 32'd0;
    logic [31:0] dat_i = 32'd0;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        irq_o;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
        string       name;
    } bus_vec_t;

    typedef struct {
        logic [7:0] s, m, h;
        logic [7:0] es, em, eh;
    } tick_vec_t;

    bus_vec_t  bus_tbl[$];
    tick_vec_t tick_tbl[$];

    rtc_alarm_top #(.CLOCK_FREQ(CLOCK_FREQ), .CNT_W(CNT_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .cyc_i (cyc_i),
        .stb_i (stb_i),
        .we_i  (we_i),
        .sel_i (sel_i),
        .adr_i (adr_i),
        .dat_i (dat_i),
        .dat_o (dat_o),
        .ack_o (ack_o),
        .irq_o (irq_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add_bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                    input logic [3:0] sel, input logic [31:0] exp, input string name);
        bus_vec_t v;
        v.we = we; v.adr = adr; v.dat = dat; v.sel = sel; v.exp = exp; v.name = name;
        bus_tbl.push_back(v);
    endfunction

    function automatic void add_tick(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h,
                                     input logic [7:0] es, input logic [7:0] em, input logic [7:0] eh);
        tick_vec_t v;
        v.s = s; v.m = m; v.h = h; v.es = es; v.em = em; v.eh = eh;
        tick_tbl.push_back(v);
    endfunction

    // Called at a negedge; the request is accepted on the next posedge (edge A)
    // and the task returns at the negedge after edge A+1: always two edges.
    task automatic xfer(input logic w, input logic [31:0] adr, input logic [31:0] wdat,
                        input logic [3:0] sel, output logic [31:0] rdat);
        logic got;
        got  = 1'b0;
        rdat = 32'd0;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = w; adr_i = adr; dat_i = wdat; sel_i = sel;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk_i);
            if (ack_o) begin
                got  = 1'b1;
                rdat = dat_o;
            end
        end
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        check("ack_seen", {31'd0, got}, 32'd1);
        @(negedge clk_i);
        check("ack_single", {31'd0, ack_o}, 32'd0);
    endtask

    task automatic wr(input logic [2:0] idx, input logic [7:0] d);
        logic [31:0] r;
        xfer(1'b1, {27'd0, idx, 2'b00}, {24'd0, d}, 4'h1, r);
    endtask

    task automatic rd_chk(input string name, input logic [2:0] idx, input logic [7:0] e);
        logic [31:0] r;
        xfer(1'b0, {27'd0, idx, 2'b00}, 32'd0, 4'h0, r);
        check(name, r, {24'd0, e});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    initial begin
        logic [31:0] r;

        // Register map, reset values, reserved bits, sel gating.
        add_bus(1'b0, 32'h18,        32'd0,         4'h0, 32'h01, "rst_ctrl");
        add_bus(1'b1, 32'h18,        32'h00,        4'h1, 32'h00, "");
        add_bus(1'b0, 32'h00,        32'd0,         4'h0, 32'h00, "rst_sec");
        add_bus(1'b0, 32'h04,        32'd0,         4'h0, 32'h00, "rst_min");
        add_bus(1'b0, 32'h08,        32'd0,         4'h0, 32'h00, "rst_hour");
        add_bus(1'b0, 32'h0C,        32'd0,         4'h0, 32'h00, "rst_alm_sec");
        add_bus(1'b0, 32'h10,        32'd0,         4'h0, 32'h00, "rst_alm_min");
        add_bus(1'b0, 32'h14,        32'd0,         4'h0, 32'h00, "rst_alm_hour");
        add_bus(1'b0, 32'h1C,        32'd0,         4'h0, 32'h00, "rst_status");
        add_bus(1'b1, 32'h10C,       32'hFFFFFF42,  4'h1, 32'h00, "");
        add_bus(1'b0, 32'h0C,        32'd0,         4'h0, 32'h42, "alm_sec_rb");
        add_bus(1'b1, 32'h10,        32'h33,        4'hE, 32'h00, "");
        add_bus(1'b0, 32'h10,        32'd0,         4'h0, 32'h00, "sel0_gate");
        add_bus(1'b1, 32'h17,        32'h21,        4'h1, 32'h00, "");
        add_bus(1'b0, 32'h14,        32'd0,         4'h0, 32'h21, "alm_hour_rb");
        add_bus(1'b1, 32'h18,        32'hFFFFFFFE,  4'h1, 32'h00, "");
        add_bus(1'b0, 32'h18,        32'd0,         4'h0, 32'h02, "ctrl_reserved");
        add_bus(1'b1, 32'h1C,        32'hFF,        4'h1, 32'h00, "");
        add_bus(1'b0, 32'h1C,        32'd0,         4'h0, 32'h00, "status_reserved");
        add_bus(1'b1, 32'h18,        32'h00,        4'h1, 32'h00, "");
        add_bus(1'b1, 32'h00,        32'h17,        4'h1, 32'h00, "");
        add_bus(1'b0, 32'h00,        32'd0,         4'h0, 32'h17, "sec_rb");
        add_bus(1'b1, 32'h04,        32'h08,        4'h1, 32'h00, "");
        add_bus(1'b0, 32'h04,        32'd0,         4'h0, 32'h08, "min_rb");
        add_bus(1'b1, 32'h08,        32'h12,        4'h1, 32'h00, "");
        add_bus(1'b0, 32'h08,        32'd0,         4'h0, 32'h12, "hour_rb");
        add_bus(1'b0, 32'h18,        32'd0,         4'h0, 32'h00, "ctrl_stopped");

        // One tick applied to {sec, min, hour} -> expected result.
        add_tick(8'h59, 8'h59, 8'h23,  8'h00, 8'h00, 8'h00);
        add_tick(8'h3A, 8'h07, 8'h05,  8'h00, 8'h08, 8'h05);
        add_tick(8'h09, 8'h00, 8'h00,  8'h10, 8'h00, 8'h00);
        add_tick(8'h59, 8'h09, 8'h00,  8'h00, 8'h10, 8'h00);
        add_tick(8'h59, 8'h59, 8'h09,  8'h00, 8'h00, 8'h10);
        add_tick(8'h59, 8'h59, 8'h19,  8'h00, 8'h00, 8'h20);
        add_tick(8'h58, 8'h59, 8'h23,  8'h59, 8'h59, 8'h23);
        add_tick(8'h60, 8'h30, 8'h12,  8'h00, 8'h31, 8'h12);
        add_tick(8'h00, 8'hA0, 8'h01,  8'h01, 8'hA0, 8'h01);
        add_tick(8'h59, 8'h6F, 8'h24,  8'h00, 8'h00, 8'h00);
        add_tick(8'h45, 8'h22, 8'h30,  8'h46, 8'h22, 8'h30);
        add_tick(8'h59, 8'h5A, 8'h02,  8'h00, 8'h00, 8'h03);

        // Reset state of the outputs.
        repeat (3) @(negedge clk_i);
        check("rst_ack_o", {31'd0, ack_o}, 32'd0);
        check("rst_irq_o", {31'd0, irq_o}, 32'd0);
        check("rst_dat_o", dat_o, 32'd0);
        rst_i = 1'b0;

        foreach (bus_tbl[i]) begin
            xfer(bus_tbl[i].we, bus_tbl[i].adr, bus_tbl[i].dat, bus_tbl[i].sel, r);
            if (!bus_tbl[i].we)
                check(bus_tbl[i].name, r, bus_tbl[i].exp);
        end

        // Each vector: load time (prescaler cleared), run exactly 10 edges, freeze, read back.
        foreach (tick_tbl[i]) begin
            wr(A_SEC, tick_tbl[i].s);
            wr(A_MIN, tick_tbl[i].m);
            wr(A_HOUR, tick_tbl[i].h);
            wr(A_CTRL, 8'h01);
            idle(8);
            wr(A_CTRL, 8'h00);
            rd_chk($sformatf("tick%0d_sec", i),  A_SEC,  tick_tbl[i].es);
            rd_chk($sformatf("tick%0d_min", i),  A_MIN,  tick_tbl[i].em);
            rd_chk($sformatf("tick%0d_hour", i), A_HOUR, tick_tbl[i].eh);
        end

        // RUN=0 freezes the prescaler; resuming finishes the remaining count.
        wr(A_SEC, 8'h10);
        wr(A_CTRL, 8'h01);
        idle(4);
        wr(A_CTRL, 8'h00);          // 6 counted edges
        idle(30);
        rd_chk("frozen_sec", A_SEC, 8'h10);
        wr(A_CTRL, 8'h01);
        wr(A_CTRL, 8'h00);          // 8 counted edges
        rd_chk("resume_no_tick", A_SEC, 8'h10);
        wr(A_CTRL, 8'h01);
        wr(A_CTRL, 8'h00);          // 10th edge ticks
        rd_chk("resume_tick", A_SEC, 8'h11);

        // A time write restarts the prescaler from 0.
        wr(A_CTRL, 8'h01);
        wr(A_CTRL, 8'h00);          // prescaler now 2
        wr(A_SEC, 8'h20);
        wr(A_CTRL, 8'h01);
        idle(6);
        wr(A_CTRL, 8'h00);          // 8 edges since the write
        rd_chk("presc_cleared", A_SEC, 8'h20);

        // Alarm at 00:00:05 with interrupt enabled.
        wr(A_STAT, 8'h01);
        wr(A_ASEC, 8'h05);
        wr(A_AMIN, 8'h00);
        wr(A_AHOUR, 8'h00);
        wr(A_MIN, 8'h00);
        wr(A_HOUR, 8'h00);
        wr(A_SEC, 8'h05);
        rd_chk("time_write_no_alarm", A_STAT, 8'h00);
        wr(A_SEC, 8'h04);
        wr(A_CTRL, 8'h03);
        idle(8);
        check("irq_before_tick", {31'd0, irq_o}, 32'd0);
        idle(1);
        check("irq_lags_alarm", {31'd0, irq_o}, 32'd0);
        idle(1);
        check("irq_set", {31'd0, irq_o}, 32'd1);
        rd_chk("alarm_flag", A_STAT, 8'h01);
        rd_chk("alarm_sec", A_SEC, 8'h05);
        wr(A_STAT, 8'h00);
        rd_chk("w0_keeps_alarm", A_STAT, 8'h01);
        wr(A_CTRL, 8'h01);
        check("irq_en_gate", {31'd0, irq_o}, 32'd0);
        wr(A_CTRL, 8'h03);
        check("irq_reenable", {31'd0, irq_o}, 32'd1);
        wr(A_STAT, 8'h01);
        check("irq_cleared", {31'd0, irq_o}, 32'd0);
        rd_chk("alarm_cleared", A_STAT, 8'h00);
        wr(A_CTRL, 8'h00);

        // Alarm set and W1C on the same edge: set wins.
        wr(A_SEC, 8'h04);
        wr(A_CTRL, 8'h01);
        idle(8);
        wr(A_STAT, 8'h01);
        rd_chk("set_beats_w1c", A_STAT, 8'h01);
        wr(A_CTRL, 8'h02);
        check("irq_after_prio", {31'd0, irq_o}, 32'd1);

        // SEC write on the tick edge: tick discarded, MIN keeps its value.
        wr(A_SEC, 8'h59);
        wr(A_MIN, 8'h15);
        wr(A_CTRL, 8'h01);
        idle(8);
        wr(A_SEC, 8'h33);
        idle(7);
        wr(A_CTRL, 8'h00);          // 9 edges after the write
        rd_chk("collide_sec", A_SEC, 8'h33);
        rd_chk("collide_min", A_MIN, 8'h15);
        wr(A_CTRL, 8'h01);
        wr(A_CTRL, 8'h00);          // 10th edge ticks
        rd_chk("collide_next_sec", A_SEC, 8'h34);
        rd_chk("collide_next_min", A_MIN, 8'h15);

        // Reset asserted while ack_o is high.
        wr(A_CTRL, 8'h02);
        check("irq_before_rst", {31'd0, irq_o}, 32'd1);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = {27'd0, A_STAT, 2'b00};
        @(negedge clk_i);
        check("ack_before_rst", {31'd0, ack_o}, 32'd1);
        check("dat_before_rst", dat_o, 32'h01);
        rst_i = 1'b1;
        #1;
        check("rst_async_ack", {31'd0, ack_o}, 32'd0);
        check("rst_async_dat", dat_o, 32'd0);
        check("rst_async_irq", {31'd0, irq_o}, 32'd0);
        cyc_i = 1'b0; stb_i = 1'b0;
        idle(2);
        rst_i = 1'b0;
        rd_chk("rst_run", A_CTRL, 8'h01);
        idle(6);
        wr(A_CTRL, 8'h00);          // 9th edge after release: no tick yet
        rd_chk("rst_sec_no_tick", A_SEC, 8'h00);

        // Reset over a pending request: no ack at all.
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; sel_i = 4'h1; adr_i = 32'd0; dat_i = 32'h44;
        rst_i = 1'b1;
        @(negedge clk_i);
        check("abort_ack0", {31'd0, ack_o}, 32'd0);
        @(negedge clk_i);
        check("abort_ack1", {31'd0, ack_o}, 32'd0);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("abort_ack2", {31'd0, ack_o}, 32'd0);

        // Reset in the middle of a running count.
        idle(3);
        rst_i = 1'b1;
        #1;
        check("midcount_ack", {31'd0, ack_o}, 32'd0);
        check("midcount_irq", {31'd0, irq_o}, 32'd0);
        idle(1);
        rst_i = 1'b0;
        rd_chk("midcount_run", A_CTRL, 8'h01);
        idle(7);
        wr(A_CTRL, 8'h00);          // 10th edge after release ticks
        rd_chk("first_tick_sec", A_SEC, 8'h01);
        rd_chk("first_tick_min", A_MIN, 8'h00);
        rd_chk("abort_no_write", A_STAT, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
